square_f32: RTL and testbench

Iterative single-precision (IEEE-754 binary32) squaring unit: the inverse companion of `squareroot_f32` in the processing-element datapath. It takes one operand `a`, computes `a*a` with a bit-serial 24x24 shift-add mantissa multiplier, rounds to nearest-even and presents the result with a `rdy` flag. The result can be fed back into `squareroot_f32` to close a round-trip check. Both blocks sit side by side in the PE arithmetic group.

---
 rtl/fp32_pkg.sv | 37 +++
 rtl/mul24_shift_add.sv | 43 ++++
 rtl/square_f32.sv | 125 ++++++++++++
 tb/tb_square_f32.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the PE arithmetic group (square_f32, squareroot_f32).
package fp32_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_W    = 8;

  localparam logic [31:0] F32_PINF     = 32'h7f80_0000;
  localparam logic [31:0] F32_ZERO     = 32'h0000_0000;
  localparam logic [31:0] F32_QNAN_BIT = 32'h0040_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StNorm,
    StDone
  } sq_state_e;

  // Zero/denormal or inf/NaN: handled without the multiplier.
  function automatic logic is_special(input fp32_t x);
    return (x.exp == '0) || (x.exp == '1);
  endfunction

  // Square of a special operand; sign is always dropped.
  function automatic logic [31:0] special_result(input fp32_t x);
    if (x.exp == '0) return F32_ZERO;
    if (x.frac == '0) return F32_PINF;
    return F32_PINF | F32_QNAN_BIT | {10'b0, x.frac[21:0]};
  endfunction

endpackage

// File: rtl/mul24_shift_add.sv
// Bit-serial 24x24 unsigned shift-add multiplier: 24 steps after a load pulse.
module mul24_shift_add (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [23:0] i_a,
  input  logic [23:0] i_b,
  output logic        o_busy,
  output logic [47:0] o_prod
);

  logic [47:0] r_mcand;
  logic [23:0] r_mplier;
  logic [47:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= {24'b0, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == 5'd23) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_prod = r_acc;

endmodule

// File: rtl/square_f32.sv
// Iterative binary32 squaring unit: serial mantissa multiply, RNE rounding, flush-to-zero.
module square_f32
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  output logic        rdy,
  output logic [31:0] sq
);

  sq_state_e   r_state, w_state_d;
  logic [7:0]  r_ea;
  logic [4:0]  r_cnt;
  logic [31:0] r_res;
  logic        r_rdy;
  logic [31:0] r_sq;

  fp32_t       w_op;
  logic        w_special;
  logic        w_accept;
  logic        w_load;
  logic        w_busy;
  logic [47:0] w_prod;

  assign w_op      = a;
  assign w_special = is_special(w_op);
  assign w_accept  = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_load    = w_accept && !w_special;

  mul24_shift_add u_mul (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_load),
    .i_a     ({1'b1, w_op.frac}),
    .i_b     ({1'b1, w_op.frac}),
    .o_busy  (w_busy),
    .o_prod  (w_prod)
  );

  logic w_unused_sign;
  logic w_unused_busy;
  assign w_unused_sign = w_op.sign;
  assign w_unused_busy = w_busy;

  // Normalise and round the 48-bit product
  logic signed [9:0] w_e_base;
  logic signed [9:0] w_e_fin;
  logic              w_hi;
  logic [22:0]       w_frac;
  logic              w_guard;
  logic              w_sticky;
  logic              w_rnd_up;
  logic [23:0]       w_frac_rnd;
  logic [31:0]       w_norm_res;

  always_comb begin
    w_e_base   = $signed({1'b0, r_ea, 1'b0}) - 10'sd127;
    w_hi       = w_prod[47];
    w_frac     = w_hi ? w_prod[46:24] : w_prod[45:23];
    w_guard    = w_hi ? w_prod[23] : w_prod[22];
    w_sticky   = w_hi ? (|w_prod[22:0]) : (|w_prod[21:0]);
    w_rnd_up   = w_guard && (w_sticky || w_frac[0]);
    w_frac_rnd = {1'b0, w_frac} + {23'b0, w_rnd_up};
    // A rounding carry leaves w_frac_rnd[22:0] at zero, which is the wanted fraction.
    w_e_fin    = w_e_base + $signed({9'b0, w_hi}) + $signed({9'b0, w_frac_rnd[23]});
    if (w_e_fin >= 10'sd255) begin
      w_norm_res = F32_PINF;
    end else if (w_e_fin <= 10'sd0) begin
      w_norm_res = F32_ZERO;
    end else begin
      w_norm_res = {1'b0, w_e_fin[7:0], w_frac_rnd[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_accept) w_state_d = w_special ? StDone : StMul;
      end
      StMul:   if (r_cnt == 5'd23) w_state_d = StNorm;
      StNorm:  w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ea  <= '0;
      r_cnt <= '0;
      r_res <= '0;
      r_rdy <= 1'b0;
      r_sq  <= '0;
    end else if (w_accept) begin
      r_rdy <= 1'b0;
      r_ea  <= w_op.exp;
      r_cnt <= '0;
      if (w_special) r_res <= special_result(w_op);
    end else begin
      case (r_state)
        StMul:  r_cnt <= r_cnt + 5'd1;
        StNorm: r_res <= w_norm_res;
        StDone: begin
          // Result is published on the first DONE edge and then held.
          if (!r_rdy) begin
            r_rdy <= 1'b1;
            r_sq  <= r_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdy = r_rdy;
  assign sq  = r_sq;

endmodule

// File: tb/tb_square_f32.sv
// Self-checking bench for square_f32 against an arithmetic reference model.
module tb_square_f32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic        rdy;
  logic [31:0] sq;

  int checks = 0;
  int errors = 0;

  square_f32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .rdy   (rdy),
    .sq    (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer square, then round-half-even by remainder comparison.
  function automatic logic [31:0] model_sq(input logic [31:0] x);
    int                ex;
    int                e;
    int                sh;
    longint unsigned   m;
    longint unsigned   p;
    longint unsigned   q;
    longint unsigned   rem;
    longint unsigned   half;
    logic [31:0]       r;
    ex = int'(x[30:23]);
    if (ex == 0) return 32'h0;
    if (ex == 255) begin
      if (x[22:0] == 23'h0) return 32'h7f80_0000;
      r = {1'b0, 8'hff, 1'b1, x[21:0]};
      return r;
    end
    m    = 64'h80_0000 + 64'(x[22:0]);
    p    = m * m;
    e    = 2 * ex - 127;
    sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
    if (sh == 24) e = e + 1;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return 32'h7f80_0000;
    if (e <= 0) return 32'h0;
    r = {1'b0, 8'(e), q[22:0]};
    return r;
  endfunction

  function automatic int model_lat(input logic [31:0] x);
    return ((x[30:23] == 8'h00) || (x[30:23] == 8'hff)) ? 1 : 26;
  endfunction

  // Issue one request and wait (bounded) for rdy; lat = -1 on timeout.
  task automatic run_op(input logic [31:0] v, output logic [31:0] res, output int lat,
                        output logic rdy0);
    @(negedge clk);
    start = 1'b1;
    a     = v;
    @(posedge clk);
    #1;
    rdy0  = rdy;
    start = 1'b0;
    a     = $urandom;
    lat   = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        lat = i;
        break;
      end
    end
    res = sq;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    a     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy: got %b want 0", rdy);
    end
    checks++;
    if (sq !== 32'h0) begin
      errors++;
      $display("FAIL reset_sq: got %h want 00000000", sq);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL idle_rdy: got %b want 0", rdy);
    end
  endtask

  task automatic check_vector(input string name, input logic [31:0] v, input logic [31:0] exp_v,
                              input int exp_lat);
    logic [31:0] res;
    int          lat;
    logic        rdy0;
    run_op(v, res, lat, rdy0);
    checks++;
    if (res !== exp_v) begin
      errors++;
      $display("FAIL %s value a=%h: got %h want %h", name, v, res, exp_v);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency a=%h: got %0d want %0d", name, v, lat, exp_lat);
    end
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL %s rdy_clear a=%h: got %b want 0", name, v, rdy0);
    end
  endtask

  task automatic test_directed();
    check_vector("sq_1p5", 32'h3fc0_0000, 32'h4010_0000, 26);
    check_vector("sq_m2", 32'hc000_0000, 32'h4080_0000, 26);
    check_vector("sq_3", 32'h4040_0000, 32'h4110_0000, 26);
    check_vector("sq_rne", 32'h3f80_0001, 32'h3f80_0002, 26);
    check_vector("sq_ovf", 32'h7f7f_ffff, 32'h7f80_0000, 26);
    check_vector("sq_unf", 32'h1f00_0000, 32'h0000_0000, 26);
  endtask

  task automatic test_specials();
    check_vector("sp_zero", 32'h0000_0000, 32'h0000_0000, 1);
    check_vector("sp_denorm", 32'h0000_0001, 32'h0000_0000, 1);
    check_vector("sp_ninf", 32'hff80_0000, 32'h7f80_0000, 1);
    check_vector("sp_snan", 32'h7fa0_0000, 32'h7fe0_0000, 1);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int n = 0; n < 40; n++) begin
      v = {1'($urandom), 8'($urandom_range(0, 255)), 23'($urandom)};
      check_vector("rand", v, model_sq(v), model_lat(v));
    end
    // Exponents near the middle exercise rounding without saturating.
    for (int n = 0; n < 20; n++) begin
      v = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      check_vector("rand_mid", v, model_sq(v), model_lat(v));
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] res;
    int          lat;
    logic        rdy0;
    run_op(32'h4040_0000, res, lat, rdy0);
    @(negedge clk);
    start = 1'b1;
    a     = 32'h3fc0_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_rdy: got %b want 0", rdy);
    end
    checks++;
    if (sq !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset_sq: got %h want 00000000", sq);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      checks++;
      if (rdy !== 1'b0) begin
        errors++;
        $display("FAIL aborted_rdy: got %b want 0", rdy);
      end
    end
    check_vector("after_reset", 32'h3fc0_0000, 32'h4010_0000, 26);
  endtask

  task automatic test_start_during_mul();
    int lat;
    @(negedge clk);
    start = 1'b1;
    a     = 32'h4040_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 32'h3fc0_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 6; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (sq !== 32'h4110_0000) begin
      errors++;
      $display("FAIL mul_ignore value: got %h want 41100000", sq);
    end
    checks++;
    if (lat != 26) begin
      errors++;
      $display("FAIL mul_ignore latency: got %0d want 26", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[4];
    vals[0] = 32'h3fc0_0000;
    vals[1] = 32'hc000_0000;
    vals[2] = 32'h7fa0_0000;
    vals[3] = 32'h3f80_0001;
    for (int k = 0; k < 4; k++) begin
      check_vector("b2b", vals[k], model_sq(vals[k]), model_lat(vals[k]));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_specials();
    test_random();
    test_reset_midop();
    test_start_during_mul();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
